sum_share_arb: RTL and testbench
================================

Name: sum_share_arb

Overview:
- Shares one "sum of last two valid values" datapath among n requesters.
- Each cycle, a round-robin arbiter grants at most one pending request.
- For the granted requester, the block adds its current value to that requester's own previous valid value, and updates that stored previous value.
- Sits between several producer ports and a single registered sum output tagged with the requester id.

Parameters:
- w, 4: data width of each requester value; the sum is w+1 bits.
- n, 4: number of requesters; must be 2, 4 or 8. Local idw = log2(n).
- ign, 0 (w bits): value to ignore; a granted value equal to ign is consumed but not summed.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_b  input  1  reset, asynchronous and active-high (rst_b=1 resets).
- req  input  n  request bit per requester; the requester holds req and its d slice until it sees gnt.
- d  input  n*w  packed values; requester k uses d[k*w +: w].
- clr  input  1  synchronous clear of all stored previous values.
- gnt  output  n  one-hot grant (combinational); a request is accepted on the posedge where its gnt=1.
- q  output  w+1  registered sum.
- q_vld  output  1  one-cycle pulse: q/q_id were updated by the last edge.
- q_id  output  idw  index of the requester that produced q.

Behaviour:
- Reset (rst_b=1, asynchronous, immediate):
  - q=0, q_vld=0, q_id=0.
  - prev[0..n-1]=0.
  - Round-robin pointer ptr=0.
  - gnt=0 while rst_b=1.
- Arbitration (combinational):
  - Scan from index ptr upward, wrapping modulo n.
  - The first k with req[k]=1 gets gnt[k]=1; all other gnt bits are 0.
  - If req=0, gnt=0.
  - If clr=1, gnt=0 regardless of req.
- Edge with clr=1:
  - All prev are set to 0 and q_vld<=0.
  - q, q_id and ptr hold.
  - No request is consumed.
- Edge with grant to k, value v=d[k*w +: w]:
  - If v != ign: q <= {1'b0,v} + {1'b0,prev[k]} (full w+1-bit result, no truncation); prev[k] <= v; q_id <= k; q_vld <= 1.
  - If v == ign: the request is consumed; q, q_id and prev[k] hold; q_vld <= 0.
  - In both cases ptr <= (k+1) mod n.
- Edge with no grant (req=0, clr=0): q_vld<=0; q, q_id, prev and ptr hold.
- Latency: one cycle from the accepting edge to q/q_vld.
  - Throughput is one accepted request per cycle.
  - Back-to-back grants to the same requester are allowed only when no other requester is pending.
- Fairness:
  - With all n requesting continuously, each requester is granted exactly once every n cycles, in index order.
  - A requester waits at most n-1 cycles.
- Stored values are independent per requester; one requester's values never enter another's sum.
- A change of req or d during a cycle in which it is not granted has no effect on state.
- Reset during operation: an in-flight q_vld is dropped immediately, and all history and the pointer are lost.

Test Plan:
1. Reset: drive rst_b=1 between clock edges while req=4'b1111 -> q=0, q_vld=0 and gnt=0 immediately, without waiting for an edge. Release rst_b -> gnt=4'b0001.
2. Single requester (w=4, n=4, ign=0): req=4'b0010, d1=7 then d1=3 on consecutive edges -> gnt=4'b0010 both cycles; outputs q=7 (q_id=1, q_vld=1), then q=10 (q_id=1).
3. Round robin: req=4'b1111 with d0..d3=1,2,3,4 held.
   - gnt sequence: 0001, 0010, 0100, 1000, 0001, ...
   - q sequence: 1, 2, 3, 4, then 2, 4, 6, 8, with q_id 0, 1, 2, 3 repeating.
4. Ignore: requester 0 sends 6, then 0, then 5 -> gnt=0001 each time; outputs q=6 (vld=1), then q_vld=0 with q held at 6, then q=11.
   - Repeat with ign=14: d=14 is ignored, and d=0 gives q=0+prev.
5. Width/overflow: requester 2 sends 15, 15 -> q=15, then q=30 (5'd30). With w=8: 255, 255 -> q=9'd510.
6. Clear: after requester 3 stores 9, assert clr=1 with req=4'b1000 -> gnt=0 and q_vld=0 next cycle. Deassert clr with d3=4 -> q=4 (prev was cleared).

Source files
------------

// File: rtl/sum_share_arb.sv
// Round-robin shared adder: sums each requester's current value with its own
// previous valid value and emits the result tagged with the requester index.
module sum_share_arb #(
    parameter int          w   = 4,
    parameter int          n   = 4,
    parameter logic [w-1:0] ign = '0
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [n-1:0]         req,
    input  logic [n*w-1:0]       d,
    input  logic                 clr,
    output logic [n-1:0]         gnt,
    output logic [w:0]           q,
    output logic                 q_vld,
    output logic [$clog2(n)-1:0] q_id
);
    localparam int idw = $clog2(n);

    logic [idw-1:0] ptr_q, ptr_d;
    logic [w:0]     q_q, q_d;
    logic           q_vld_q, q_vld_d;
    logic [idw-1:0] q_id_q, q_id_d;
    logic [w-1:0]   prev_q [n];
    logic [w-1:0]   prev_d [n];

    logic           hit;
    logic [idw-1:0] gnt_idx;
    logic [idw-1:0] scan_idx;
    logic [w-1:0]   v;

    // n is a power of two, so the idw-bit sum wraps modulo n for free.
    always_comb begin
        hit      = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int i = 0; i < n; i++) begin
            scan_idx = ptr_q + idw'(i);
            if (!hit && req[scan_idx]) begin
                hit     = 1'b1;
                gnt_idx = scan_idx;
            end
        end
        if (clr) begin
            hit = 1'b0;
        end
    end

    assign gnt = (hit && !rst_b) ? (n'(1) << gnt_idx) : '0;
    assign v   = d[int'(gnt_idx)*w +: w];

    always_comb begin
        ptr_d   = ptr_q;
        q_d     = q_q;
        q_id_d  = q_id_q;
        q_vld_d = 1'b0;
        prev_d  = prev_q;
        if (clr) begin
            for (int k = 0; k < n; k++) begin
                prev_d[k] = '0;
            end
        end else if (hit) begin
            ptr_d = gnt_idx + idw'(1);
            // An ignored value is consumed but leaves history and output alone.
            if (v != ign) begin
                q_d             = {1'b0, v} + {1'b0, prev_q[gnt_idx]};
                prev_d[gnt_idx] = v;
                q_id_d          = gnt_idx;
                q_vld_d         = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            ptr_q   <= '0;
            q_q     <= '0;
            q_vld_q <= 1'b0;
            q_id_q  <= '0;
            for (int k = 0; k < n; k++) begin
                prev_q[k] <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            q_q     <= q_d;
            q_vld_q <= q_vld_d;
            q_id_q  <= q_id_d;
            prev_q  <= prev_d;
        end
    end

    assign q     = q_q;
    assign q_vld = q_vld_q;
    assign q_id  = q_id_q;
endmodule

// File: tb/tb_sum_share_arb.sv
// Bench for sum_share_arb: per-cycle comparison against a behavioural model of
// the default instance, plus directed literal checks on all three instances.
module tb_sum_share_arb;
    logic        clk;
    logic        rst_b;
    logic [3:0]  req;
    logic [15:0] d;
    logic [31:0] d8;
    logic        clr;

    logic [3:0]  gnt,  gnt2,  gnt3;
    logic [4:0]  q,    q2;
    logic [8:0]  q3;
    logic        q_vld, q_vld2, q_vld3;
    logic [1:0]  q_id, q_id2, q_id3;

    int checks   = 0;
    int failures = 0;

    sum_share_arb #(.w(4), .n(4), .ign(4'd0)) dut (
        .clk(clk), .rst_b(rst_b), .req(req), .d(d), .clr(clr),
        .gnt(gnt), .q(q), .q_vld(q_vld), .q_id(q_id));

    sum_share_arb #(.w(4), .n(4), .ign(4'd14)) dut2 (
        .clk(clk), .rst_b(rst_b), .req(req), .d(d), .clr(clr),
        .gnt(gnt2), .q(q2), .q_vld(q_vld2), .q_id(q_id2));

    sum_share_arb #(.w(8), .n(4), .ign(8'd0)) dut3 (
        .clk(clk), .rst_b(rst_b), .req(req), .d(d8), .clr(clr),
        .gnt(gnt3), .q(q3), .q_vld(q_vld3), .q_id(q_id3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model of the default instance.
    int m_prev [4] = '{0, 0, 0, 0};
    int m_ptr = 0;
    int m_q   = 0;
    int m_id  = 0;
    int m_vld = 0;

    function automatic int model_pick();
        if (rst_b || clr) return -1;
        for (int i = 0; i < 4; i++) begin
            if (req[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_gnt();
        int k;
        k = model_pick();
        if (k < 0) return 4'b0000;
        return 4'b0001 << k;
    endfunction

    always @(posedge clk or posedge rst_b) begin
        int k;
        int val;
        if (rst_b) begin
            for (int i = 0; i < 4; i++) m_prev[i] = 0;
            m_ptr = 0; m_q = 0; m_id = 0; m_vld = 0;
        end else begin
            k = model_pick();
            m_vld = 0;
            if (clr) begin
                for (int i = 0; i < 4; i++) m_prev[i] = 0;
            end else if (k >= 0) begin
                val   = (d >> (4 * k)) & 15;
                m_ptr = (k + 1) % 4;
                if (val != 0) begin
                    m_q       = val + m_prev[k];
                    m_prev[k] = val;
                    m_id      = k;
                    m_vld     = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model_gnt",   32'(gnt),   32'(model_gnt()));
        chk("model_q",     32'(q),     32'(m_q));
        chk("model_q_vld", 32'(q_vld), 32'(m_vld));
        chk("model_q_id",  32'(q_id),  32'(m_id));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_b = 1'b1;
        req   = 4'b1111;
        d     = '0;
        d8    = '0;
        clr   = 1'b0;

        #3;
        chk("rst_q",     32'(q),     0);
        chk("rst_q_vld", 32'(q_vld), 0);
        chk("rst_gnt",   32'(gnt),   0);

        // Round robin from a clean reset.
        #9;
        rst_b = 1'b0;
        d     = 16'h4321;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (i % 4)));
            step();
            chk("rr_q",     32'(q),     (i < 4) ? 32'(i + 1) : 32'(2 * (i % 4 + 1)));
            chk("rr_q_id",  32'(q_id),  32'(i % 4));
            chk("rr_q_vld", 32'(q_vld), 1);
        end

        // Asynchronous reset between edges with a result in flight.
        rst_b = 1'b1;
        #1;
        chk("midrst_q",     32'(q),     0);
        chk("midrst_q_vld", 32'(q_vld), 0);
        chk("midrst_gnt",   32'(gnt),   0);
        rst_b = 1'b0;
        #1;
        chk("rel_gnt", 32'(gnt), 32'(4'b0001));
        req = 4'b0000;
        step();

        // Single requester accumulates its own history.
        req = 4'b0010;
        d   = 16'h0070;
        #1;
        chk("single_gnt0", 32'(gnt), 32'(4'b0010));
        step();
        chk("single_q0",    32'(q),    7);
        chk("single_id0",   32'(q_id), 1);
        chk("single_vld0",  32'(q_vld), 1);
        d = 16'h0030;
        #1;
        chk("single_gnt1", 32'(gnt), 32'(4'b0010));
        step();
        chk("single_q1",   32'(q),    10);
        chk("single_id1",  32'(q_id), 1);
        req = 4'b0000;
        step();
        chk("idle_vld", 32'(q_vld), 0);
        chk("idle_q",   32'(q),     10);

        // Ignore value: ign=0 on dut, ign=14 on dut2.
        req = 4'b0001;
        d   = 16'h0006;
        #1;
        chk("ign_gnt", 32'(gnt), 32'(4'b0001));
        step();
        chk("ign_q0",    32'(q),      6);
        chk("ign_vld0",  32'(q_vld),  1);
        chk("ign2_q0",   32'(q2),     6);
        d = 16'h0000;
        step();
        chk("ign_vld1",  32'(q_vld),  0);
        chk("ign_q1",    32'(q),      6);
        chk("ign2_q1",   32'(q2),     6);
        chk("ign2_vld1", 32'(q_vld2), 1);
        d = 16'h0005;
        step();
        chk("ign_q2",    32'(q),      11);
        chk("ign2_q2",   32'(q2),     5);
        d = 16'h000E;
        step();
        chk("ign_q3",    32'(q),      19);
        chk("ign2_vld3", 32'(q_vld2), 0);
        chk("ign2_q3",   32'(q2),     5);
        req = 4'b0000;
        step();

        // Full-width sums without truncation.
        req = 4'b0100;
        d   = 16'h0F00;
        d8  = 32'h00FF_0000;
        step();
        chk("ovf_q0",  32'(q),  15);
        chk("ovf8_q0", 32'(q3), 255);
        step();
        chk("ovf_q1",  32'(q),    30);
        chk("ovf_id1", 32'(q_id), 2);
        chk("ovf8_q1", 32'(q3),   510);
        req = 4'b0000;
        step();

        // Synchronous clear of history.
        req = 4'b1000;
        d   = 16'h9000;
        step();
        chk("clr_q0", 32'(q), 9);
        clr = 1'b1;
        #1;
        chk("clr_gnt", 32'(gnt), 0);
        step();
        chk("clr_vld", 32'(q_vld), 0);
        chk("clr_q",   32'(q),     9);
        chk("clr_id",  32'(q_id),  3);
        clr = 1'b0;
        d   = 16'h4000;
        step();
        chk("clr_q1",   32'(q),     4);
        chk("clr_vld1", 32'(q_vld), 1);

        // Partial requests exercise pointer wrap with gaps.
        req = 4'b0101;
        d   = 16'h0302;
        for (int i = 0; i < 4; i++) step();
        req = 4'b0000;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
